sockit_spi_axi_burst: RTL and testbench

- AXI4 slave front end bridging burst memory-mapped transfers to the SPI data streams: write data stream (sdw) and read data stream (sdr).
- Generalises the single-beat DMA port with these additions:
  - parametrised data and ID widths;
  - full INCR/FIXED burst support with beat counting;
  - WLAST/RLAST tracking;
  - SLVERR for unsupported requests;
  - B response issued only after the last write beat.
- Sits between the system AXI interconnect and the sockit_spi stream FIFOs.

---
 rtl/sockit_spi_axi_burst.sv | 242 ++++++++++++++++++++++++
 tb/tb_sockit_spi_axi_burst.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sockit_spi_axi_burst.sv
// sockit_spi_axi_burst: AXI4 burst slave bridging memory-mapped transfers onto
// the SPI write stream (sdw) and read stream (sdr). The address is ignored,
// so FIXED and INCR bursts behave the same. WRAP, reserved burst types and
// non-native beat sizes are answered with SLVERR.
// Optional macro SOCKIT_SPI_AXI_BURST_RSLICE_EN adds a one-entry register
// slice on the R channel. The default build keeps R combinational.
module sockit_spi_axi_burst #(
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int SW = DW/8
)(
    input  logic          ACLK,
    input  logic          ARESETn,
    // write address
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [IW-1:0] AWID,
    input  logic [7:0]    AWLEN,
    input  logic [2:0]    AWSIZE,
    input  logic [1:0]    AWBURST,
    // write data
    input  logic          WVALID,
    output logic          WREADY,
    input  logic [DW-1:0] WDATA,
    input  logic [SW-1:0] WSTRB,
    input  logic          WLAST,
    // write response
    output logic          BVALID,
    input  logic          BREADY,
    output logic [IW-1:0] BID,
    output logic [1:0]    BRESP,
    // read address
    input  logic          ARVALID,
    output logic          ARREADY,
    input  logic [IW-1:0] ARID,
    input  logic [7:0]    ARLEN,
    input  logic [2:0]    ARSIZE,
    input  logic [1:0]    ARBURST,
    // read data
    output logic          RVALID,
    input  logic          RREADY,
    output logic [IW-1:0] RID,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    RRESP,
    output logic          RLAST,
    // SPI streams
    output logic          sdw_vld,
    input  logic          sdw_rdy,
    output logic [DW-1:0] sdw_dat,
    input  logic          sdr_vld,
    output logic          sdr_rdy,
    input  logic [DW-1:0] sdr_dat
);

    localparam logic [2:0] SIZE_OK = 3'($clog2(SW));
    localparam logic [1:0] OKAY    = 2'd0;
    localparam logic [1:0] SLVERR  = 2'd2;

    // Byte strobes carry no meaning for a stream target.
    logic unused_wstrb;
    assign unused_wstrb = ^WSTRB;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    wstate_t       wstate, wstate_nxt;
    logic [IW-1:0] bid_q;
    logic          werr, wlast_err;
    logic [7:0]    wcnt;
    logic          aw_err, w_beat;

    // Bursts other than FIXED/INCR (burst[1] set) or a non-native size are errors.
    assign aw_err  = (AWSIZE != SIZE_OK) | AWBURST[1];
    assign w_beat  = (wstate == W_DATA) & WVALID & WREADY;
    assign sdw_dat = WDATA;
    assign BID     = bid_q;

    // Write state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) wstate <= W_IDLE;
        else          wstate <= wstate_nxt;
    end

    // Write burst context: ID, error flag, remaining beats, WLAST consistency.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bid_q     <= '0;
            werr      <= 1'b0;
            wcnt      <= '0;
            wlast_err <= 1'b0;
        end else begin
            if (wstate == W_IDLE && AWVALID) begin
                bid_q     <= AWID;
                werr      <= aw_err;
                wcnt      <= AWLEN;
                wlast_err <= 1'b0;
            end
            if (w_beat) begin
                // AWLEN governs the burst length; a misplaced WLAST only taints BRESP.
                if (WLAST != (wcnt == 8'd0)) wlast_err <= 1'b1;
                if (wcnt != 8'd0)            wcnt      <= wcnt - 8'd1;
            end
        end
    end

    // Write next-state and handshake outputs.
    always_comb begin
        wstate_nxt = wstate;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        sdw_vld    = 1'b0;
        BVALID     = 1'b0;
        BRESP      = OKAY;
        case (wstate)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                if (werr) begin
                    // Errored bursts are sunk so the master can finish its beats.
                    WREADY = 1'b1;
                end else begin
                    sdw_vld = WVALID;
                    WREADY  = sdw_rdy;
                end
                if (WVALID && WREADY && wcnt == 8'd0) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                BRESP  = (werr | wlast_err) ? SLVERR : OKAY;
                if (BREADY) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t       rstate, rstate_nxt;
    logic [IW-1:0] rid_q;
    logic          rerr;
    logic [7:0]    rcnt;
    logic          ar_err, ar_go, r_beat, slice_rdy, slice_idle;
    logic          src_vld, src_last;
    logic [DW-1:0] src_data;
    logic [1:0]    src_resp;

    assign ar_err = (ARSIZE != SIZE_OK) | ARBURST[1];
    assign ar_go  = (rstate == R_IDLE) & ARVALID & ARREADY;

    // Beat source before the optional slice: errored bursts synthesize
    // zero data and never touch the stream.
    assign src_vld  = (rstate == R_DATA) & (rerr | sdr_vld);
    assign src_data = (rstate == R_DATA && !rerr) ? sdr_dat : '0;
    assign src_resp = (rstate == R_DATA && rerr) ? SLVERR : OKAY;
    assign src_last = (rstate == R_DATA) & (rcnt == 8'd0);
    assign r_beat   = src_vld & slice_rdy;
    assign sdr_rdy  = (rstate == R_DATA) & ~rerr & slice_rdy;
    assign ARREADY  = (rstate == R_IDLE) & slice_idle;

`ifdef SOCKIT_SPI_AXI_BURST_RSLICE_EN
    logic          rvalid_q, rlast_q;
    logic [IW-1:0] rid_out_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    // The slice accepts a new beat whenever it is empty or draining.
    assign slice_rdy  = RREADY | ~rvalid_q;
    assign slice_idle = ~rvalid_q;

    // One-entry R register slice.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_out_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            if (slice_rdy) rvalid_q <= src_vld;
            if (r_beat) begin
                rlast_q   <= src_last;
                rid_out_q <= rid_q;
                rdata_q   <= src_data;
                rresp_q   <= src_resp;
            end
        end
    end

    assign RVALID = rvalid_q;
    assign RLAST  = rlast_q;
    assign RID    = rid_out_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
`else
    assign slice_rdy  = RREADY;
    assign slice_idle = 1'b1;
    assign RVALID     = src_vld;
    assign RLAST      = src_last;
    assign RID        = rid_q;
    assign RDATA      = src_data;
    assign RRESP      = src_resp;
`endif

    // Read state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rstate <= R_IDLE;
        else          rstate <= rstate_nxt;
    end

    // Read burst context: ID, error flag, remaining beats.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid_q <= '0;
            rerr  <= 1'b0;
            rcnt  <= '0;
        end else if (ar_go) begin
            rid_q <= ARID;
            rerr  <= ar_err;
            rcnt  <= ARLEN;
        end else if (r_beat && rcnt != 8'd0) begin
            rcnt  <= rcnt - 8'd1;
        end
    end

    // Read next-state: leave R_DATA once the last beat is handed on.
    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_go) rstate_nxt = R_DATA;
            R_DATA:  if (r_beat && rcnt == 8'd0) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sockit_spi_axi_burst.sv
// Directed bench for sockit_spi_axi_burst, default (combinational R) build.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sockit_spi_axi_burst;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW/8;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          AWVALID, AWREADY;
    logic [IW-1:0] AWID;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          WVALID, WREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST;
    logic          BVALID, BREADY;
    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic          ARVALID, ARREADY;
    logic [IW-1:0] ARID;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          RVALID, RREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          sdw_vld, sdw_rdy;
    logic [DW-1:0] sdw_dat;
    logic          sdr_vld, sdr_rdy;
    logic [DW-1:0] sdr_dat;

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    sockit_spi_axi_burst #(.DW(DW), .IW(IW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .sdw_vld(sdw_vld), .sdw_rdy(sdw_rdy), .sdw_dat(sdw_dat),
        .sdr_vld(sdr_vld), .sdr_rdy(sdr_rdy), .sdr_dat(sdr_dat)
    );

    task automatic test_reset();
        ARESETn = 1'b0;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        WVALID = 0; WDATA = 0; WSTRB = '1; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
        sdw_rdy = 0; sdr_vld = 0; sdr_dat = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); #1;
        tests++;
        if ({BVALID, RVALID, BID, RID, BRESP, RRESP, RLAST} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got B%0b R%0b BID%0d RID%0d BR%0d RR%0d RL%0b want all 0",
                     BVALID, RVALID, BID, RID, BRESP, RRESP, RLAST);
        end
        tests++;
        if ({AWREADY, ARREADY, WREADY, sdr_rdy} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_ready: got aw%0b ar%0b w%0b sdr%0b want 1100",
                     AWREADY, ARREADY, WREADY, sdr_rdy);
        end
        ARESETn = 1'b1;
    endtask

    task automatic test_write();
        @(negedge ACLK);
        AWVALID = 1; AWID = 5; AWLEN = 3; AWSIZE = 2; AWBURST = 1; sdw_rdy = 1;
        #1; tests++;
        if (AWREADY !== 1'b1) begin fails++; $display("FAIL wr_awready: got %0b want 1", AWREADY); end
        @(negedge ACLK);
        AWVALID = 0;
        for (int i = 0; i < 4; i++) begin
            WVALID = 1; WDATA = 32'h11 * (i + 1); WLAST = (i == 3);
            #1; tests++;
            if ({WREADY, sdw_vld, BVALID, AWREADY} !== 4'b1100 || sdw_dat !== 32'h11 * (i + 1)) begin
                fails++;
                $display("FAIL wr_beat%0d: got wr%0b vld%0b b%0b aw%0b dat %h want 1100 dat %h",
                         i, WREADY, sdw_vld, BVALID, AWREADY, sdw_dat, 32'h11 * (i + 1));
            end
            @(negedge ACLK);
        end
        WVALID = 0; WLAST = 0;
        #1; tests++;
        if ({BVALID, BID, BRESP} !== {1'b1, 4'd5, 2'd0}) begin
            fails++;
            $display("FAIL wr_bresp: got v%0b id%0d resp%0d want v1 id5 resp0", BVALID, BID, BRESP);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        #1; tests++;
        if ({BVALID, AWREADY} !== 2'b01) begin
            fails++;
            $display("FAIL wr_done: got b%0b aw%0b want b0 aw1", BVALID, AWREADY);
        end
    endtask

    task automatic test_write_size_err();
        @(negedge ACLK);
        AWVALID = 1; AWID = 2; AWLEN = 1; AWSIZE = 1; AWBURST = 1; sdw_rdy = 0;
        @(negedge ACLK);
        AWVALID = 0;
        for (int i = 0; i < 2; i++) begin
            WVALID = 1; WDATA = 32'hA0 + i; WLAST = (i == 1);
            #1; tests++;
            if ({WREADY, sdw_vld, BVALID} !== 3'b100) begin
                fails++;
                $display("FAIL wsize_beat%0d: got wr%0b vld%0b b%0b want 100", i, WREADY, sdw_vld, BVALID);
            end
            @(negedge ACLK);
        end
        WVALID = 0; WLAST = 0;
        #1; tests++;
        if ({BVALID, BID, BRESP} !== {1'b1, 4'd2, 2'd2}) begin
            fails++;
            $display("FAIL wsize_bresp: got v%0b id%0d resp%0d want v1 id2 resp2", BVALID, BID, BRESP);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    task automatic test_early_wlast();
        @(negedge ACLK);
        AWVALID = 1; AWID = 7; AWLEN = 2; AWSIZE = 2; AWBURST = 0; sdw_rdy = 1;
        @(negedge ACLK);
        AWVALID = 0;
        for (int i = 0; i < 3; i++) begin
            WVALID = 1; WDATA = 32'hB0 + i; WLAST = (i == 1);
            #1; tests++;
            if ({WREADY, sdw_vld, BVALID} !== 3'b110 || sdw_dat !== 32'hB0 + i) begin
                fails++;
                $display("FAIL ewlast_beat%0d: got wr%0b vld%0b b%0b dat %h want 110 dat %h",
                         i, WREADY, sdw_vld, BVALID, sdw_dat, 32'hB0 + i);
            end
            @(negedge ACLK);
        end
        WVALID = 0; WLAST = 0;
        #1; tests++;
        if ({BVALID, BID, BRESP} !== {1'b1, 4'd7, 2'd2}) begin
            fails++;
            $display("FAIL ewlast_bresp: got v%0b id%0d resp%0d want v1 id7 resp2", BVALID, BID, BRESP);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    task automatic test_read_backpressure();
        int k = 0;
        int cyc = 0;
        @(negedge ACLK);
        ARVALID = 1; ARID = 3; ARLEN = 7; ARSIZE = 2; ARBURST = 1;
        #1; tests++;
        if (ARREADY !== 1'b1) begin fails++; $display("FAIL rd_arready: got %0b want 1", ARREADY); end
        @(negedge ACLK);
        ARVALID = 0; sdr_vld = 1;
        while (k < 8 && cyc < 40) begin
            RREADY = (cyc % 2 == 0);
            sdr_dat = k;
            #1; tests++;
            if ({RVALID, RLAST, RID, RRESP, sdr_rdy, ARREADY} !== {1'b1, k == 7, 4'd3, 2'd0, RREADY, 1'b0}
                || RDATA !== 32'(k)) begin
                fails++;
                $display("FAIL rd_beat%0d: got v%0b last%0b id%0d resp%0d sdr_rdy%0b ar%0b dat %0d want v1 last%0b id3 resp0 sdr_rdy%0b ar0 dat %0d",
                         k, RVALID, RLAST, RID, RRESP, sdr_rdy, ARREADY, RDATA, k == 7, RREADY, k);
            end
            if (RREADY) k++;
            cyc++;
            @(negedge ACLK);
        end
        RREADY = 0; sdr_vld = 0;
        #1; tests++;
        if ({RVALID, ARREADY, sdr_rdy} !== 3'b010 || k != 8) begin
            fails++;
            $display("FAIL rd_done: got v%0b ar%0b sdr_rdy%0b beats %0d want v0 ar1 sdr_rdy0 beats 8",
                     RVALID, ARREADY, sdr_rdy, k);
        end
    endtask

    task automatic test_read_wrap();
        @(negedge ACLK);
        ARVALID = 1; ARID = 1; ARLEN = 1; ARSIZE = 2; ARBURST = 2;
        @(negedge ACLK);
        ARVALID = 0; sdr_vld = 1; sdr_dat = 32'hDEAD_BEEF; RREADY = 1;
        for (int i = 0; i < 2; i++) begin
            #1; tests++;
            if ({RVALID, RLAST, RRESP, sdr_rdy, RID} !== {1'b1, i == 1, 2'd2, 1'b0, 4'd1} || RDATA !== '0) begin
                fails++;
                $display("FAIL wrap_beat%0d: got v%0b last%0b resp%0d sdr_rdy%0b id%0d dat %h want v1 last%0b resp2 sdr_rdy0 id1 dat 0",
                         i, RVALID, RLAST, RRESP, sdr_rdy, RID, RDATA, i == 1);
            end
            @(negedge ACLK);
        end
        RREADY = 0; sdr_vld = 0;
        #1; tests++;
        if ({RVALID, ARREADY} !== 2'b01) begin
            fails++;
            $display("FAIL wrap_done: got v%0b ar%0b want v0 ar1", RVALID, ARREADY);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge ACLK);
        AWVALID = 1; AWID = 4; AWLEN = 3; AWSIZE = 2; AWBURST = 1;
        ARVALID = 1; ARID = 8; ARLEN = 3; ARSIZE = 2; ARBURST = 1;
        #1; tests++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            fails++;
            $display("FAIL mid_both_accept: got aw%0b ar%0b want 11", AWREADY, ARREADY);
        end
        @(negedge ACLK);
        AWVALID = 0; ARVALID = 0;
        sdw_rdy = 1; WVALID = 1; WDATA = 32'h1; WLAST = 0;
        sdr_vld = 1; sdr_dat = 32'h1; RREADY = 1;
        @(negedge ACLK);
        WDATA = 32'h2; sdr_dat = 32'h2;
        #1 ARESETn = 1'b0;
        #1; tests++;
        if ({RVALID, BVALID, sdw_vld, WREADY, sdr_rdy, RLAST} !== 6'b0) begin
            fails++;
            $display("FAIL mid_abort: got rv%0b bv%0b sdw%0b wr%0b sdr%0b rl%0b want all 0",
                     RVALID, BVALID, sdw_vld, WREADY, sdr_rdy, RLAST);
        end
        WVALID = 0; sdr_vld = 0; RREADY = 0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1; tests++;
        if ({AWREADY, ARREADY, RVALID, BVALID} !== 4'b1100) begin
            fails++;
            $display("FAIL mid_release: got aw%0b ar%0b rv%0b bv%0b want 1100", AWREADY, ARREADY, RVALID, BVALID);
        end
        // Fresh single-beat write and read after the abort.
        @(negedge ACLK);
        AWVALID = 1; AWID = 9; AWLEN = 0; AWSIZE = 2; AWBURST = 1;
        ARVALID = 1; ARID = 6; ARLEN = 0; ARSIZE = 2; ARBURST = 0;
        @(negedge ACLK);
        AWVALID = 0; ARVALID = 0;
        WVALID = 1; WDATA = 32'h5A; WLAST = 1;
        sdr_vld = 1; sdr_dat = 32'hC3; RREADY = 1;
        #1; tests++;
        if ({WREADY, sdw_vld, RVALID, RLAST, RID, RRESP} !== {4'b1111, 4'd6, 2'd0}
            || sdw_dat !== 32'h5A || RDATA !== 32'hC3) begin
            fails++;
            $display("FAIL post_beat: got wr%0b sdw%0b rv%0b rl%0b id%0d rr%0d sdw_dat %h rdata %h want 1111 id6 rr0 5a c3",
                     WREADY, sdw_vld, RVALID, RLAST, RID, RRESP, sdw_dat, RDATA);
        end
        @(negedge ACLK);
        WVALID = 0; WLAST = 0; sdr_vld = 0; RREADY = 0;
        #1; tests++;
        if ({BVALID, BID, BRESP, RVALID, ARREADY} !== {1'b1, 4'd9, 2'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL post_resp: got bv%0b bid%0d br%0d rv%0b ar%0b want bv1 bid9 br0 rv0 ar1",
                     BVALID, BID, BRESP, RVALID, ARREADY);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_size_err();
        test_early_wlast();
        test_read_backpressure();
        test_read_wrap();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
